alu_result_writeback: RTL and testbench

- Return path of the ALU datapath: takes the 8-bit ALU result plus a 3-bit destination code and commits it to A, X, Y, SP or an external memory store.
- Owns the architectural A/X/Y/SP registers and the N/Z status bits. Its register outputs feed the operand-select mux on the ALU input side.
- Register writes complete in one cycle. Memory stores use a request/acknowledge handshake that stalls the writeback port.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/wb_store_ctrl.sv | 68 ++++++
 rtl/alu_result_writeback.sv | 104 ++++++++++
 tb/tb_alu_result_writeback.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath: destination/mux select codes,
// writeback FSM state encoding and the stack pointer reset default.
package alu_pkg;

  localparam int unsigned DEST_W = 3;

  // Destination codes double as the ALU operand-select codes.
  localparam logic [DEST_W-1:0] DEST_NONE = 3'd0;
  localparam logic [DEST_W-1:0] DEST_A    = 3'd1;
  localparam logic [DEST_W-1:0] DEST_X    = 3'd2;
  localparam logic [DEST_W-1:0] DEST_Y    = 3'd3;
  localparam logic [DEST_W-1:0] DEST_MEM  = 3'd4;
  localparam logic [DEST_W-1:0] DEST_SP   = 3'd5;

  localparam logic [7:0] SP_RESET_DEFAULT = 8'hFD;

  typedef enum logic {
    WB_IDLE  = 1'b0,
    WB_STORE = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_store_ctrl.sv
// Writeback store handshake: IDLE accepts writebacks, STORE holds the
// memory request until acknowledged and stalls the writeback port.
module wb_store_ctrl
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [DEST_W-1:0] wb_dest,
  input  logic [7:0]        wb_result,
  input  logic              mem_ack,
  output logic              wb_ready,
  output logic              busy,
  output logic              mem_we,
  output logic [7:0]        mem_wdata
);

  wb_state_e  state_q, state_d;
  logic       mem_we_q, mem_we_d;
  logic [7:0] mem_wdata_q, mem_wdata_d;

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    wb_ready    = 1'b0;
    busy        = 1'b0;
    case (state_q)
      WB_IDLE: begin
        // mem_ack is deliberately ignored here: an ack on the edge that
        // launches a store belongs to an earlier request.
        wb_ready = 1'b1;
        if (wb_valid && (wb_dest == DEST_MEM)) begin
          mem_wdata_d = wb_result;
          mem_we_d    = 1'b1;
          state_d     = WB_STORE;
        end
      end
      WB_STORE: begin
        busy = 1'b1;
        if (mem_ack) begin
          mem_we_d = 1'b0;
          state_d  = WB_IDLE;
        end
      end
      default: begin
        state_d  = WB_IDLE;
        mem_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WB_IDLE;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: rtl/alu_result_writeback.sv
// ALU result writeback: owns A/X/Y/SP and N/Z, commits results or issues stores.
// Optional macro ALU_WB_BYPASS_EN makes register/flag outputs show same-cycle writes.
module alu_result_writeback
  import alu_pkg::*;
#(
  parameter logic [7:0] SP_RESET = SP_RESET_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [DEST_W-1:0] wb_dest,
  input  logic [7:0]        wb_result,
  input  logic              wb_update_nz,
  output logic [7:0]        a_reg,
  output logic [7:0]        x_reg,
  output logic [7:0]        y_reg,
  output logic [7:0]        sp,
  output logic              flag_n,
  output logic              flag_z,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              busy
);

  logic [7:0] a_q, a_d, x_q, x_d, y_q, y_d, sp_q, sp_d;
  logic       n_q, n_d, z_q, z_d;
  logic       xfer;

  wb_store_ctrl u_store_ctrl (
    .clk       (clk),
    .rst       (rst),
    .wb_valid  (wb_valid),
    .wb_dest   (wb_dest),
    .wb_result (wb_result),
    .mem_ack   (mem_ack),
    .wb_ready  (wb_ready),
    .busy      (busy),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );

  assign xfer = wb_valid && wb_ready;

  always_comb begin
    a_d  = a_q;
    x_d  = x_q;
    y_d  = y_q;
    sp_d = sp_q;
    n_d  = n_q;
    z_d  = z_q;
    if (xfer) begin
      case (wb_dest)
        DEST_A:  a_d  = wb_result;
        DEST_X:  x_d  = wb_result;
        DEST_Y:  y_d  = wb_result;
        DEST_SP: sp_d = wb_result;
        default: ;
      endcase
      // Flags follow the transfer even for MEM and discard destinations.
      if (wb_update_nz) begin
        n_d = wb_result[7];
        z_d = (wb_result == 8'h00);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      x_q  <= '0;
      y_q  <= '0;
      sp_q <= SP_RESET;
      n_q  <= 1'b0;
      z_q  <= 1'b0;
    end else begin
      a_q  <= a_d;
      x_q  <= x_d;
      y_q  <= y_d;
      sp_q <= sp_d;
      n_q  <= n_d;
      z_q  <= z_d;
    end
  end

`ifdef ALU_WB_BYPASS_EN
  // Next-state values equal wb_result only during an accepted transfer.
  assign a_reg  = a_d;
  assign x_reg  = x_d;
  assign y_reg  = y_d;
  assign sp     = sp_d;
  assign flag_n = n_d;
  assign flag_z = z_d;
`else
  assign a_reg  = a_q;
  assign x_reg  = x_q;
  assign y_reg  = y_q;
  assign sp     = sp_q;
  assign flag_n = n_q;
  assign flag_z = z_q;
`endif

endmodule

// File: tb/tb_alu_result_writeback.sv
// Directed, table-driven bench for alu_result_writeback plus store/reset sequences.
module tb_alu_result_writeback;

  logic       clk = 1'b0;
  logic       rst;
  logic       wb_valid;
  logic       wb_ready;
  logic [2:0] wb_dest;
  logic [7:0] wb_result;
  logic       wb_update_nz;
  logic [7:0] a_reg, x_reg, y_reg, sp;
  logic       flag_n, flag_z;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_ack;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_result_writeback #(.SP_RESET(8'hFD)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_dest      (wb_dest),
    .wb_result    (wb_result),
    .wb_update_nz (wb_update_nz),
    .a_reg        (a_reg),
    .x_reg        (x_reg),
    .y_reg        (y_reg),
    .sp           (sp),
    .flag_n       (flag_n),
    .flag_z       (flag_z),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_ack      (mem_ack),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [2:0] dest;
    logic [7:0] res;
    logic       upd;
    logic [7:0] ea, ex, ey, esp;
    logic       en, ez;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic [7:0] ea, input logic [7:0] ex,
                            input logic [7:0] ey, input logic [7:0] esp,
                            input logic en, input logic ez);
    check({tag, " a_reg"},  32'(a_reg),  32'(ea));
    check({tag, " x_reg"},  32'(x_reg),  32'(ex));
    check({tag, " y_reg"},  32'(y_reg),  32'(ey));
    check({tag, " sp"},     32'(sp),     32'(esp));
    check({tag, " flag_n"}, 32'(flag_n), 32'(en));
    check({tag, " flag_z"}, 32'(flag_z), 32'(ez));
  endtask

  // Advance past the next rising edge; inputs change and outputs settle at +1.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] d, input logic [7:0] r, input logic u);
    wb_valid     = v;
    wb_dest      = d;
    wb_result    = r;
    wb_update_nz = u;
  endtask

  initial begin
    rst = 1'b1;
    mem_ack = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 1'b0);

    vecs[0] = '{1'b1, 3'd1, 8'h80, 1'b1, 8'h80, 8'h00, 8'h00, 8'hFD, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 3'd2, 8'h00, 1'b1, 8'h80, 8'h00, 8'h00, 8'hFD, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 3'd6, 8'h33, 1'b1, 8'h80, 8'h00, 8'h00, 8'hFD, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 3'd0, 8'h33, 1'b1, 8'h80, 8'h00, 8'h00, 8'hFD, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 3'd5, 8'hFF, 1'b0, 8'h80, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 3'd3, 8'hC3, 1'b1, 8'h80, 8'h00, 8'hC3, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 3'd7, 8'h00, 1'b0, 8'h80, 8'h00, 8'hC3, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 3'd1, 8'h55, 1'b1, 8'h80, 8'h00, 8'hC3, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 3'd2, 8'h7F, 1'b1, 8'h80, 8'h7F, 8'hC3, 8'hFF, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 3'd1, 8'h81, 1'b1, 8'h81, 8'h7F, 8'hC3, 8'hFF, 1'b1, 1'b0};

    // Reset held for two cycles.
    step();
    step();
    rst = 1'b0;
    #1;
    check_regs("reset", 8'h00, 8'h00, 8'h00, 8'hFD, 1'b0, 1'b0);
    check("reset mem_we",    32'(mem_we),    32'd0);
    check("reset mem_wdata", 32'(mem_wdata), 32'd0);
    check("reset busy",      32'(busy),      32'd0);
    check("reset wb_ready",  32'(wb_ready),  32'd1);

    // Single-cycle register/flag transfers.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].valid, vecs[i].dest, vecs[i].res, vecs[i].upd);
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
      #1;
      check_regs($sformatf("vec%0d", i), vecs[i].ea, vecs[i].ex, vecs[i].ey,
                 vecs[i].esp, vecs[i].en, vecs[i].ez);
      check($sformatf("vec%0d mem_we", i), 32'(mem_we), 32'd0);
    end

    // Store launch, with an ack on the launch edge that must be ignored.
    drive(1'b1, 3'd4, 8'h5A, 1'b1);
    mem_ack = 1'b1;
    step();
    drive(1'b1, 3'd1, 8'h11, 1'b0);
    mem_ack = 1'b0;
    #1;
    check("store mem_we",    32'(mem_we),    32'd1);
    check("store mem_wdata", 32'(mem_wdata), 32'h5A);
    check("store busy",      32'(busy),      32'd1);
    check("store wb_ready",  32'(wb_ready),  32'd0);
    check("store flag_n",    32'(flag_n),    32'd0);
    check("store flag_z",    32'(flag_z),    32'd0);

    // Stall for three cycles with a pending register writeback.
    for (int c = 0; c < 3; c++) begin
      step();
      #1;
      check($sformatf("stall%0d a_reg", c),     32'(a_reg),     32'h81);
      check($sformatf("stall%0d mem_we", c),    32'(mem_we),    32'd1);
      check($sformatf("stall%0d mem_wdata", c), 32'(mem_wdata), 32'h5A);
      check($sformatf("stall%0d wb_ready", c),  32'(wb_ready),  32'd0);
    end

    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    #1;
    check("ack mem_we",   32'(mem_we),   32'd0);
    check("ack busy",     32'(busy),     32'd0);
    check("ack wb_ready", 32'(wb_ready), 32'd1);
`ifndef ALU_WB_BYPASS_EN
    check("ack a_reg",    32'(a_reg),    32'h81);
`endif
    step();
    wb_valid = 1'b0;
    #1;
    check_regs("accept", 8'h11, 8'h7F, 8'hC3, 8'hFF, 1'b0, 1'b0);

    // Reset while a store is outstanding.
    drive(1'b1, 3'd4, 8'hA5, 1'b0);
    step();
    wb_valid = 1'b0;
    #1;
    check("store2 mem_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rst_store mem_we",    32'(mem_we),    32'd0);
    check("rst_store busy",      32'(busy),      32'd0);
    check("rst_store mem_wdata", 32'(mem_wdata), 32'd0);
    check_regs("rst_store", 8'h00, 8'h00, 8'h00, 8'hFD, 1'b0, 1'b0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    #1;
    check("late_ack mem_we",   32'(mem_we),   32'd0);
    check("late_ack wb_ready", 32'(wb_ready), 32'd1);
    check("late_ack busy",     32'(busy),     32'd0);

    // Same-cycle visibility depends on the bypass option.
    drive(1'b1, 3'd3, 8'hC3, 1'b1);
    #1;
`ifdef ALU_WB_BYPASS_EN
    check("bypass y_reg",  32'(y_reg),  32'hC3);
    check("bypass flag_n", 32'(flag_n), 32'd1);
`else
    check("nobypass y_reg",  32'(y_reg),  32'h00);
    check("nobypass flag_n", 32'(flag_n), 32'd0);
`endif
    step();
    wb_valid = 1'b0;
    #1;
    check("post_edge y_reg",  32'(y_reg),  32'hC3);
    check("post_edge flag_n", 32'(flag_n), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
